// File: rtl/dmem_arb_pkg.sv
// Shared encodings for the data-memory arbiter: FSM states and port ownership.
package dmem_arb_pkg;

    typedef enum logic {
        S_CORE  = 1'b0,
        S_FORCE = 1'b1
    } arb_state_e;

    typedef enum logic {
        OWN_CORE = 1'b0,
        OWN_HOST = 1'b1
    } owner_e;

endpackage

// File: rtl/dmem_arbiter.sv
// Shares the single data_memory port between the MIPS core (priority) and a host port.
// A host kept waiting HOST_MAX_WAIT contended cycles gets one forced slot, stalling the core.
module dmem_arbiter
    import dmem_arb_pkg::*;
#(
    parameter int AW            = 32,
    parameter int DW            = 32,
    parameter int HOST_MAX_WAIT = 4,
    parameter int SCW           = 16
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          core_req,
    input  logic          core_we,
    input  logic [AW-1:0] core_addr,
    input  logic [DW-1:0] core_wdata,
    output logic [DW-1:0] core_rdata,
    output logic          core_stall,
    input  logic          host_valid,
    input  logic          host_we,
    input  logic [AW-1:0] host_addr,
    input  logic [DW-1:0] host_wdata,
    output logic          host_ready,
    output logic [DW-1:0] host_rdata,
    output logic          host_rvalid,
    output logic [AW-1:0] mem_a,
    output logic [DW-1:0] mem_wd,
    output logic          mem_we,
    input  logic [DW-1:0] mem_rd,
    output logic [SCW-1:0] stall_count
);

    localparam int WCW = (HOST_MAX_WAIT > 1) ? $clog2(HOST_MAX_WAIT) : 1;
    localparam logic [WCW-1:0] WAIT_LAST = WCW'(HOST_MAX_WAIT - 1);

    // Host handshake: a request is held on host_valid with stable fields until host_ready
    // is seen high in the same cycle; that cycle is the access. Writes commit at its closing
    // edge, reads return on host_rdata with a one-cycle host_rvalid pulse one cycle later.

    arb_state_e     state_q, state_d;
    logic [WCW-1:0] wait_cnt_q, wait_cnt_d;
    owner_e         owner;
    logic           host_grant;
    logic           core_grant;
    logic           stall;

    always_comb begin
        state_d    = state_q;
        wait_cnt_d = wait_cnt_q;
        owner      = OWN_CORE;
        host_grant = 1'b0;
        core_grant = 1'b0;
        stall      = 1'b0;
        case (state_q)
            S_CORE: begin
                if (core_req) begin
                    core_grant = 1'b1;
                    if (host_valid) begin
                        if (wait_cnt_q == WAIT_LAST) begin
                            state_d    = S_FORCE;
                            wait_cnt_d = '0;
                        end else begin
                            wait_cnt_d = wait_cnt_q + 1'b1;
                        end
                    end else begin
                        wait_cnt_d = '0;
                    end
                end else begin
                    wait_cnt_d = '0;
                    if (host_valid) begin
                        owner      = OWN_HOST;
                        host_grant = 1'b1;
                    end
                end
            end
            S_FORCE: begin
                // A host that withdrew leaves the slot idle rather than stalling the core.
                owner      = OWN_HOST;
                host_grant = host_valid;
                stall      = core_req & host_valid;
                state_d    = S_CORE;
                wait_cnt_d = '0;
            end
            default: begin
                state_d    = S_CORE;
                wait_cnt_d = '0;
            end
        endcase
        if (!rst) begin
            state_d    = S_CORE;
            wait_cnt_d = '0;
            host_grant = 1'b0;
            core_grant = 1'b0;
            stall      = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        state_q    <= state_d;
        wait_cnt_q <= wait_cnt_d;
    end

    assign mem_a      = (owner == OWN_HOST) ? host_addr  : core_addr;
    assign mem_wd     = (owner == OWN_HOST) ? host_wdata : core_wdata;
    assign mem_we     = (host_grant & host_we) | (core_grant & core_we);
    assign core_rdata = mem_rd;
    assign core_stall = stall;
    assign host_ready = host_grant;

    logic          host_rvalid_q, host_rvalid_d;
    logic [DW-1:0] host_rdata_q, host_rdata_d;

    always_comb begin
        host_rvalid_d = host_grant & ~host_we;
        host_rdata_d  = host_rvalid_d ? mem_rd : host_rdata_q;
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            host_rvalid_q <= 1'b0;
            host_rdata_q  <= '0;
        end else begin
            host_rvalid_q <= host_rvalid_d;
            host_rdata_q  <= host_rdata_d;
        end
    end

    assign host_rvalid = host_rvalid_q;
    assign host_rdata  = host_rdata_q;

    logic [SCW-1:0] stall_count_q, stall_count_d;

    always_comb begin
        stall_count_d = stall_count_q;
        if (stall && (stall_count_q != {SCW{1'b1}})) begin
            stall_count_d = stall_count_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            stall_count_q <= '0;
        end else begin
            stall_count_q <= stall_count_d;
        end
    end

    assign stall_count = stall_count_q;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Bench for dmem_arbiter: directed scenarios plus randomized traffic against a
// cycle-level reference model of grants, stalls, memory contents and host reads.
module tb_dmem_arbiter;

    localparam int AW   = 32;
    localparam int DW   = 32;
    localparam int MAXW = 4;
    localparam int SCW  = 16;

    // clock / reset
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst;
    logic          core_req, core_we;
    logic [AW-1:0] core_addr;
    logic [DW-1:0] core_wdata;
    logic [DW-1:0] core_rdata;
    logic          core_stall;
    logic          host_valid, host_we;
    logic [AW-1:0] host_addr;
    logic [DW-1:0] host_wdata;
    logic          host_ready;
    logic [DW-1:0] host_rdata;
    logic          host_rvalid;
    logic [AW-1:0] mem_a;
    logic [DW-1:0] mem_wd;
    logic          mem_we;
    logic [DW-1:0] mem_rd;
    logic [SCW-1:0] stall_count;

    dmem_arbiter #(.AW(AW), .DW(DW), .HOST_MAX_WAIT(MAXW), .SCW(SCW)) dut (
        .clk(clk), .rst(rst),
        .core_req(core_req), .core_we(core_we), .core_addr(core_addr),
        .core_wdata(core_wdata), .core_rdata(core_rdata), .core_stall(core_stall),
        .host_valid(host_valid), .host_we(host_we), .host_addr(host_addr),
        .host_wdata(host_wdata), .host_ready(host_ready), .host_rdata(host_rdata),
        .host_rvalid(host_rvalid), .mem_a(mem_a), .mem_wd(mem_wd), .mem_we(mem_we),
        .mem_rd(mem_rd), .stall_count(stall_count)
    );

    // data_memory stand-in: combinational read, write on rising edge
    logic [DW-1:0] mem [64];
    logic          mem_init;
    assign mem_rd = mem[mem_a[7:2]];
    always @(posedge clk) begin
        if (mem_init) begin
            for (int i = 0; i < 64; i++) mem[i] <= '0;
        end else if (mem_we === 1'b1) begin
            mem[mem_a[7:2]] <= mem_wd;
        end
    end

    // second instance for counter saturation with a narrow counter
    logic          s_rst, s_core_req, s_host_valid;
    logic          s_zero1;
    logic [AW-1:0] s_zero_a;
    logic [DW-1:0] s_zero_d;
    logic [DW-1:0] s_core_rdata, s_host_rdata, s_mem_wd;
    logic [AW-1:0] s_mem_a;
    logic          s_core_stall, s_host_ready, s_host_rvalid, s_mem_we;
    logic [1:0]    s_stall_count;

    dmem_arbiter #(.AW(AW), .DW(DW), .HOST_MAX_WAIT(1), .SCW(2)) dut_sat (
        .clk(clk), .rst(s_rst),
        .core_req(s_core_req), .core_we(s_zero1), .core_addr(s_zero_a),
        .core_wdata(s_zero_d), .core_rdata(s_core_rdata), .core_stall(s_core_stall),
        .host_valid(s_host_valid), .host_we(s_zero1), .host_addr(s_zero_a),
        .host_wdata(s_zero_d), .host_ready(s_host_ready), .host_rdata(s_host_rdata),
        .host_rvalid(s_host_rvalid), .mem_a(s_mem_a), .mem_wd(s_mem_wd), .mem_we(s_mem_we),
        .mem_rd(s_zero_d), .stall_count(s_stall_count)
    );

    // scoreboard state
    int checks   = 0;
    int failures = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=0x%08h exp=0x%08h", tag, got, exp);
        end
    endtask

    // reference model: waiting time of the host in contended cycles, memory image, read queue
    int            hwait;
    int            exp_stalls;
    bit            exp_rvalid;
    logic [DW-1:0] ref_mem [64];
    logic [DW-1:0] exp_q [$];
    bit            p_forced, p_ready, p_stall, p_core_done, p_we;

    // observed values at the mid-cycle sample
    logic          obs_ready, obs_stall, obs_rvalid;
    logic [DW-1:0] obs_rdata;

    task automatic predict();
        p_forced = (hwait >= MAXW);
        if (!rst) begin
            p_ready     = 1'b0;
            p_stall     = 1'b0;
            p_core_done = 1'b0;
        end else if (p_forced) begin
            p_ready     = host_valid;
            p_stall     = core_req && host_valid;
            p_core_done = 1'b0;
        end else begin
            p_ready     = host_valid && !core_req;
            p_stall     = 1'b0;
            p_core_done = core_req;
        end
        p_we = p_ready ? host_we : (p_core_done && core_we);
    endtask

    task automatic check_outputs(input string ctx);
        obs_ready  = host_ready;
        obs_stall  = core_stall;
        obs_rvalid = host_rvalid;
        obs_rdata  = host_rdata;
        check_eq({ctx, ".host_ready"}, host_ready, p_ready);
        check_eq({ctx, ".core_stall"}, core_stall, p_stall);
        check_eq({ctx, ".mem_we"}, mem_we, p_we);
        check_eq({ctx, ".stall_count"}, stall_count, exp_stalls);
        check_eq({ctx, ".host_rvalid"}, host_rvalid, exp_rvalid);
        if (exp_rvalid && exp_q.size() > 0)
            check_eq({ctx, ".host_rdata"}, host_rdata, exp_q[0]);
        if (p_core_done && !core_we)
            check_eq({ctx, ".core_rdata"}, core_rdata, ref_mem[core_addr[7:2]]);
        if (p_we) begin
            check_eq({ctx, ".mem_a"}, mem_a, p_ready ? host_addr : core_addr);
            check_eq({ctx, ".mem_wd"}, mem_wd, p_ready ? host_wdata : core_wdata);
        end
    endtask

    task automatic update();
        if (!rst) begin
            hwait      = 0;
            exp_stalls = 0;
            exp_rvalid = 1'b0;
            exp_q.delete();
        end else begin
            if (exp_rvalid && exp_q.size() > 0) void'(exp_q.pop_front());
            if (p_stall && exp_stalls < (2**SCW - 1)) exp_stalls++;
            exp_rvalid = p_ready && !host_we;
            if (exp_rvalid) exp_q.push_back(ref_mem[host_addr[7:2]]);
            if (p_ready && host_we) ref_mem[host_addr[7:2]] = host_wdata;
            else if (p_core_done && core_we) ref_mem[core_addr[7:2]] = core_wdata;
            if (p_forced) hwait = 0;
            else if (host_valid && core_req) hwait = hwait + 1;
            else hwait = 0;
        end
    endtask

    // driver: inputs are already set just after a rising edge
    task automatic cycle(input string ctx);
        predict();
        @(negedge clk);
        check_outputs(ctx);
        @(posedge clk);
        update();
        #1;
    endtask

    task automatic set_core(input logic req, input logic we, input logic [AW-1:0] a,
                            input logic [DW-1:0] d);
        core_req   = req;
        core_we    = we;
        core_addr  = a;
        core_wdata = d;
    endtask

    task automatic set_host(input logic v, input logic we, input logic [AW-1:0] a,
                            input logic [DW-1:0] d);
        host_valid = v;
        host_we    = we;
        host_addr  = a;
        host_wdata = d;
    endtask

    bit h_pend;

    initial begin
        hwait = 0; exp_stalls = 0; exp_rvalid = 1'b0;
        for (int i = 0; i < 64; i++) ref_mem[i] = '0;
        s_rst = 1'b0; s_core_req = 1'b0; s_host_valid = 1'b0;
        s_zero1 = 1'b0; s_zero_a = '0; s_zero_d = '0;
        mem_init = 1'b1;

        // 1. reset with both sides requesting
        rst = 1'b0;
        set_core(1'b1, 1'b1, 32'h4, 32'hAAAA);
        set_host(1'b1, 1'b1, 32'h8, 32'hBBBB);
        @(posedge clk); #1;
        mem_init = 1'b0;
        repeat (2) cycle("reset");
        check_eq("reset.rvalid_const", obs_rvalid, 1'b0);
        check_eq("reset.count_const", stall_count, 0);

        // 2. host-only write then read
        rst = 1'b1;
        set_core(1'b0, 1'b0, 32'h0, 32'h0);
        set_host(1'b1, 1'b1, 32'h10, 32'hDEADBEEF);
        cycle("t2.wr");
        check_eq("t2.wr_ready", obs_ready, 1'b1);
        set_host(1'b1, 1'b0, 32'h10, 32'h0);
        cycle("t2.rd");
        check_eq("t2.rd_ready", obs_ready, 1'b1);
        set_host(1'b0, 1'b0, 32'h0, 32'h0);
        cycle("t2.ret");
        check_eq("t2.rvalid", obs_rvalid, 1'b1);
        check_eq("t2.rdata", obs_rdata, 32'hDEADBEEF);

        // 3. sustained contention: forced slot after four waits
        set_core(1'b1, 1'b0, 32'h0, 32'h0);
        set_host(1'b1, 1'b1, 32'h30, 32'h55);
        for (int i = 0; i < 6; i++) begin
            if (i == 5) host_valid = 1'b0;
            cycle("t3");
            check_eq($sformatf("t3.ready%0d", i), obs_ready, (i == 4));
            check_eq($sformatf("t3.stall%0d", i), obs_stall, (i == 4));
        end
        check_eq("t3.stall_count", stall_count, 1);

        // 4. core store blocked by forced host store to the same word
        set_core(1'b1, 1'b1, 32'h20, 32'h1111);
        set_host(1'b1, 1'b1, 32'h20, 32'h2222);
        for (int i = 0; i < 6; i++) begin
            if (i == 5) host_valid = 1'b0;
            cycle("t4");
            if (i == 4) check_eq("t4.mem_after_force", mem[8], 32'h2222);
            if (i == 5) check_eq("t4.mem_after_retry", mem[8], 32'h1111);
        end
        check_eq("t4.stall_count", stall_count, 2);

        // 5. host withdraws after two contended cycles; waiting restarts from zero
        set_core(1'b1, 1'b0, 32'h40, 32'h0);
        set_host(1'b1, 1'b0, 32'h44, 32'h0);
        for (int i = 0; i < 8; i++) begin
            if (i == 2) host_valid = 1'b0;
            cycle("t5");
            check_eq($sformatf("t5.stall%0d", i), obs_stall, 1'b0);
            check_eq($sformatf("t5.ready%0d", i), obs_ready, 1'b0);
        end
        host_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            if (i == 4) check_eq("t5.rewait_count", stall_count, 2);
            cycle("t5b");
            check_eq($sformatf("t5b.ready%0d", i), obs_ready, (i == 4));
        end
        host_valid = 1'b0;
        cycle("t5c");

        // randomized traffic with occasional resets and host withdrawals
        h_pend = 1'b0;
        for (int n = 0; n < 600; n++) begin
            rst = ($urandom_range(0, 99) != 0);
            set_core($urandom_range(0, 3) != 0, $urandom_range(0, 1),
                     {24'h0, 6'($urandom_range(0, 63)), 2'b00}, $urandom);
            if (!h_pend && $urandom_range(0, 2) == 0) begin
                set_host(1'b1, $urandom_range(0, 1),
                         {24'h0, 6'($urandom_range(0, 63)), 2'b00}, $urandom);
                h_pend = 1'b1;
            end else if (h_pend && hwait < MAXW && $urandom_range(0, 29) == 0) begin
                h_pend = 1'b0;
            end
            host_valid = h_pend;
            cycle("rand");
            if (p_ready || !rst) h_pend = 1'b0;
        end
        rst = 1'b1;
        set_core(1'b0, 1'b0, 32'h0, 32'h0);
        set_host(1'b0, 1'b0, 32'h0, 32'h0);
        repeat (2) cycle("drain");

        // 6. narrow counter saturates at 3 with a stall every other cycle
        s_rst = 1'b0; s_core_req = 1'b1; s_host_valid = 1'b1;
        @(posedge clk); #1;
        s_rst = 1'b1;
        for (int n = 0; n < 10; n++) begin
            @(negedge clk);
            check_eq($sformatf("sat.stall%0d", n), s_core_stall, (n % 2 == 1));
            @(posedge clk); #1;
            check_eq($sformatf("sat.count%0d", n), s_stall_count,
                     ((n + 1) / 2 > 3) ? 3 : (n + 1) / 2);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
